counter_uart_tx: RTL and testbench

- Serialises the 4-bit LED counter value as one ASCII hex character, optionally followed by CR LF, on the UART TX pin.
- Sits directly downstream of the counter inside the tt_um_4bits_uart top level. Its output drives the uo_out TX bit.
- Uses 8N1 framing with a fixed, parameterised bit period. A one-shot send strobe from the top level starts each message.

---
 rtl/counter_uart_pkg.sv | 15 +
 rtl/uart_tx_byte.sv | 85 ++++++++
 rtl/counter_uart_tx.sv | 82 ++++++++
 tb/tb_counter_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_uart_pkg.sv
// Shared types and ASCII helpers for the counter UART transmitter.
package counter_uart_pkg;

   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_0     = 8'h30;
   localparam logic [7:0] CHAR_A_OFS = 8'h37;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (CHAR_0 + {4'h0, nib}) : (CHAR_A_OFS + {4'h0, nib});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 shifter; tx falls on the edge that accepts a byte.
// Ready in IDLE and on the last stop-bit cycle, so a waiting byte chains with no gap.
module uart_tx_byte
   import counter_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1042
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       byte_vld_i,
   input  logic [7:0] byte_dat_i,
   output logic       byte_rdy_o,
   output logic       byte_end_o,
   output logic       tx_o
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   state_t          state_q;
   logic [BW-1:0]   baud_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            tx_q;
   logic            baud_end;

   assign baud_end   = (baud_q == BAUD_LAST);
   assign byte_end_o = (state_q == STOP) && baud_end;
   assign byte_rdy_o = (state_q == IDLE) || byte_end_o;
   assign tx_o       = tx_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         baud_q <= ((state_q == IDLE) || baud_end) ? '0 : baud_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (byte_vld_i) begin
                  shift_q <= byte_dat_i;
                  tx_q    <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  tx_q    <= shift_q[0];
                  bit_q   <= '0;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (baud_end) begin
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     // shift_q[1] is the bit that becomes LSB after this shift
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 3'd1;
                  end
               end
            end
            STOP: begin
               if (baud_end) begin
                  if (byte_vld_i) begin
                     shift_q <= byte_dat_i;
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/counter_uart_tx.sv
// Sends the 4-bit counter as one ASCII hex digit (plus optional CR LF) over 8N1 UART.
// tx/busy change on the edge after accept; send is ignored while busy, with no queuing.
module counter_uart_tx
   import counter_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1042,
   parameter bit APPEND_CRLF  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       send,
   input  logic [3:0] value,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] LAST_IDX = APPEND_CRLF ? 2'd2 : 2'd0;

   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [1:0] idx_q, idx_d;
   logic       accept;
   logic       byte_vld, byte_rdy, byte_end;
   logic [7:0] byte_dat;

   assign accept   = ena & send & ~busy_q;
   // The digit goes straight into the shifter on accept, so later value changes cannot leak in.
   assign byte_vld = accept | (busy_q & (idx_q != LAST_IDX));

   always_comb begin
      byte_dat = CHAR_LF;
      if (accept)
         byte_dat = hex_to_ascii(value);
      else if (idx_q == 2'd0)
         byte_dat = CHAR_CR;
   end

   always_comb begin
      busy_d = busy_q;
      idx_d  = idx_q;
      done_d = 1'b0;
      if (accept) begin
         busy_d = 1'b1;
         idx_d  = 2'd0;
      end else if (busy_q && byte_end && (idx_q == LAST_IDX)) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
      if (busy_q && byte_vld && byte_rdy)
         idx_d = idx_q + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         idx_q  <= 2'd0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         idx_q  <= idx_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .byte_vld_i (byte_vld),
      .byte_dat_i (byte_dat),
      .byte_rdy_o (byte_rdy),
      .byte_end_o (byte_end),
      .tx_o       (tx)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_counter_uart_tx.sv
// Bench for counter_uart_tx: a CR LF instance (a) and a digit-only instance (b), CLKS_PER_BIT=4.
module tb_counter_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b0, send = 1'b0;
   logic [3:0] value = 4'h0;
   logic       ena_b = 1'b0, send_b = 1'b0;
   logic [3:0] value_b = 4'h0;
   logic       tx_a, busy_a, done_a;
   logic       tx_b, busy_b, done_b;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   typedef struct {
      logic [3:0] value;
      logic [7:0] ascii;
   } vec_t;
   vec_t vecs[5];

   counter_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .send(send), .value(value),
      .tx(tx_a), .busy(busy_a), .done(done_a)
   );

   counter_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena_b), .send(send_b), .value(value_b),
      .tx(tx_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // UART receiver: samples mid-bit on falling clock edges and pops the expected byte.
   task automatic monitor(input int which);
      int         cnt = 0;
      bit         inframe = 0;
      logic [7:0] sh = '0;
      logic       txv;
      forever begin
         @(negedge clk);
         txv = (which != 0) ? tx_b : tx_a;
         if (!rst_n) begin
            inframe = 0;
         end else if (!inframe) begin
            if (txv == 1'b0) begin
               inframe = 1;
               cnt = 0;
            end
         end else begin
            cnt++;
            if (cnt == 2) check("start_bit", txv, 0);
            else if (cnt >= 6 && cnt <= 34 && ((cnt - 6) % 4) == 0) sh[(cnt - 6) / 4] = txv;
            else if (cnt == 38) begin
               check("stop_bit", txv, 1);
               if (which == 0) begin
                  check("a_frame_expected", exp_a.size() > 0, 1);
                  if (exp_a.size() > 0) check("a_frame_byte", sh, exp_a.pop_front());
               end else begin
                  check("b_frame_expected", exp_b.size() > 0, 1);
                  if (exp_b.size() > 0) check("b_frame_byte", sh, exp_b.pop_front());
               end
            end else if (cnt == 39) inframe = 0;
         end
      end
   endtask

   // Called at the first falling edge after accept; returns at the falling edge where busy dropped.
   task automatic run_msg(input int which, input string tag, input int exp_len);
      int n = 0;
      while ((((which != 0) ? busy_b : busy_a) === 1'b1) && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_busy_len"}, n, exp_len);
      check({tag, "_done"}, (which != 0) ? done_b : done_a, 1);
   endtask

   initial monitor(0);
   initial monitor(1);

   initial forever begin
      @(negedge clk);
      if (done_a === 1'b1) done_cnt_a++;
      if (done_b === 1'b1) done_cnt_b++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1);
   end

   initial begin
      int bad;
      int d0;
      vecs[0] = '{4'hA, 8'h41};
      vecs[1] = '{4'h0, 8'h30};
      vecs[2] = '{4'h9, 8'h39};
      vecs[3] = '{4'hF, 8'h46};
      vecs[4] = '{4'h5, 8'h35};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_a", tx_a, 1);
      check("rst_busy_a", busy_a, 0);
      check("rst_done_a", done_a, 0);
      check("rst_tx_b", tx_b, 1);
      check("rst_busy_b", busy_b, 0);
      check("rst_done_b", done_b, 0);
      rst_n = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_a !== 1 || busy_a !== 0 || done_a !== 0 || tx_b !== 1 || busy_b !== 0 || done_b !== 0) bad++;
      end
      check("idle_hold", bad, 0);

      for (int i = 0; i < 5; i++) begin
         value = vecs[i].value;
         ena = 1'b1;
         send = 1'b1;
         exp_a.push_back(vecs[i].ascii);
         exp_a.push_back(8'h0D);
         exp_a.push_back(8'h0A);
         @(negedge clk);
         send = 1'b0;
         check("vec_first_start", tx_a, 0);
         check("vec_busy_rise", busy_a, 1);
         run_msg(0, "vec", 120);
         @(negedge clk);
         check("vec_done_1cyc", done_a, 0);
      end
      check("vec_done_count", done_cnt_a, 5);

      value_b = 4'h7;
      ena_b = 1'b1;
      send_b = 1'b1;
      exp_b.push_back(8'h37);
      @(negedge clk);
      send_b = 1'b0;
      check("crlf0_start", tx_b, 0);
      fork
         begin
            repeat (9) @(negedge clk);
            send_b = 1'b1;
            @(negedge clk);
            send_b = 1'b0;
         end
      join_none
      run_msg(1, "crlf0", 40);
      @(negedge clk);
      check("crlf0_done_1cyc", done_b, 0);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_b !== 1 || busy_b !== 0) bad++;
      end
      check("crlf0_no_second", bad, 0);
      check("crlf0_done_count", done_cnt_b, 1);
      check("crlf0_queue_empty", exp_b.size(), 0);

      ena = 1'b0;
      send = 1'b1;
      value = 4'h2;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_a !== 1 || busy_a !== 0) bad++;
      end
      check("ena_gate", bad, 0);
      ena = 1'b1;
      exp_a.push_back(8'h32);
      exp_a.push_back(8'h0D);
      exp_a.push_back(8'h0A);
      @(negedge clk);
      check("ena_start_tx", tx_a, 0);
      send = 1'b0;
      ena = 1'b0;
      value = 4'h3;
      run_msg(0, "ena", 120);
      @(negedge clk);

      value = 4'h1;
      ena = 1'b1;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      repeat (17) @(negedge clk);
      check("pre_reset_bit3", tx_a, 0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_tx", tx_a, 1);
      check("midrst_busy", busy_a, 0);
      check("midrst_done", done_a, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_idle", tx_a, 1);
      value = 4'h0;
      send = 1'b1;
      exp_a.push_back(8'h30);
      exp_a.push_back(8'h0D);
      exp_a.push_back(8'h0A);
      @(negedge clk);
      send = 1'b0;
      check("postrst_start", tx_a, 0);
      run_msg(0, "postrst", 120);
      @(negedge clk);

      value = 4'hF;
      ena = 1'b1;
      send = 1'b1;
      for (int m = 0; m < 3; m++) begin
         exp_a.push_back(8'h46);
         exp_a.push_back(8'h0D);
         exp_a.push_back(8'h0A);
      end
      d0 = done_cnt_a;
      @(negedge clk);
      check("hold_start", tx_a, 0);
      for (int m = 0; m < 3; m++) begin
         run_msg(0, "hold", 120);
         check("hold_gap_tx", tx_a, 1);
         if (m == 2) send = 1'b0;
         @(negedge clk);
         check("hold_done_1cyc", done_a, 0);
         if (m < 2) check("hold_restart", tx_a, 0);
         else check("hold_stop", busy_a, 0);
      end
      repeat (50) @(negedge clk);
      check("hold_done_count", done_cnt_a - d0, 3);
      check("a_queue_empty", exp_a.size(), 0);
      check("b_queue_empty", exp_b.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
